edge_event_arbiter: RTL and testbench

//   Watches N_CH asynchronous-free level inputs and turns each rising edge into a queued event.

---
 rtl/edge_evt_pkg.sv | 37 +++
 rtl/rise_counter.sv | 51 +++++
 rtl/edge_event_arbiter.sv | 84 ++++++++
 tb/tb_edge_event_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/edge_evt_pkg.sv
// Shared defaults and the round-robin winner search for the edge event arbiter.
package edge_evt_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 3;
  // Widest request vector rr_pick can search; channel counts above this are unsupported.
  localparam int RR_MAX    = 32;

  // Returns the first requesting index after ptr, searching ptr+1, ptr+2, ...
  // wrapping modulo n_ch. Returns ptr unchanged when nothing requests.
  function automatic logic [31:0] rr_pick(input logic [RR_MAX-1:0] req,
                                          input logic [31:0]       ptr,
                                          input logic [31:0]       n_ch);
    logic [31:0] idx;
    logic [31:0] win;
    logic        found;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = ptr + 32'(k);
      if (idx >= n_ch) begin
        idx = idx - n_ch;
      end else begin
        idx = idx;
      end
      // idx is below n_ch (<= RR_MAX) whenever k <= n_ch, so 5 bits suffice
      if (!found && (32'(k) <= n_ch) && req[idx[4:0]]) begin
        found = 1'b1;
        win   = idx;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rise_counter.sv
// Per-channel rising-edge detector with a saturating count of undelivered edges
// and a sticky overflow flag for edges dropped at saturation.
module rise_counter
  import edge_evt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             dec,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             r_din_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_inc;

  // A rise is a high level that was low on the previous cycle; reset treats din as low.
  assign w_inc = din & ~r_din_q;

  // Track the previous level and update the pending count; inc+dec together cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_din_q <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
      r_ovf   <= 1'b0;
    end else begin
      r_din_q <= din;
      case ({w_inc, dec})
        2'b10: begin
          if (r_cnt == CNT_MAX) begin
            r_ovf <= 1'b1;
          end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        2'b01:   r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign pend_cnt = r_cnt;
  assign ovf      = r_ovf;

endmodule

// File: rtl/edge_event_arbiter.sv
// Turns rising edges on N_CH level inputs into events, queued per channel as
// saturating counts, and serialises them round-robin onto one valid/ready port.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] din,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [ID_W-1:0] ev_id,
  output logic            pend_any,
  output logic [N_CH-1:0] ovf
);

  logic [CNT_W-1:0] w_pend_cnt [N_CH];
  logic [N_CH-1:0]  w_req;
  logic [N_CH-1:0]  w_dec;
  logic             w_any;
  logic             w_free;
  logic             w_load;
  logic [ID_W-1:0]  w_win;

  logic             r_ev_valid;
  logic [ID_W-1:0]  r_ev_id;
  logic [ID_W-1:0]  r_rr_ptr;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      rise_counter #(
        .CNT_W (CNT_W)
      ) u_rise_counter (
        .clk      (clk),
        .reset    (reset),
        .din      (din[g]),
        .dec      (w_dec[g]),
        .pend_cnt (w_pend_cnt[g]),
        .ovf      (ovf[g])
      );
      // Only the channel chosen for this load gives up one pending edge.
      assign w_dec[g] = w_load && (w_win == ID_W'(g));
    end
  endgenerate

  // Channels with any undelivered edges request the output stage.
  always_comb begin
    w_req = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      w_req[i] = (w_pend_cnt[i] != {CNT_W{1'b0}});
    end
  end

  assign w_any  = |w_req;
  assign w_free = !r_ev_valid || ev_ready;
  assign w_load = w_free && w_any;
  assign w_win  = ID_W'(rr_pick(RR_MAX'(w_req), 32'(r_rr_ptr), 32'(N_CH)));

  // Output register: reload whenever the slot is empty or being accepted this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ev_valid <= 1'b0;
      r_ev_id    <= {ID_W{1'b0}};
      r_rr_ptr   <= ID_W'(N_CH - 1);
    end else if (w_load) begin
      r_ev_valid <= 1'b1;
      r_ev_id    <= w_win;
      r_rr_ptr   <= w_win;
    end else if (w_free) begin
      r_ev_valid <= 1'b0;
    end else begin
      r_ev_valid <= r_ev_valid;
    end
  end

  assign ev_valid = r_ev_valid;
  assign ev_id    = r_ev_id;
  assign pend_any = w_any;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (N_CH=4, CNT_W=3).
module tb_edge_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] din;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_id;
  logic       pend_any;
  logic [3:0] ovf;

  int n_checks;
  int n_fail;
  int ev_cnt;

  edge_event_arbiter #(
    .N_CH  (4),
    .CNT_W (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_id    (ev_id),
    .pend_any (pend_any),
    .ovf      (ovf)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] d);
    reset    = 1'b1;
    din      = d;
    ev_ready = 1'b0;
    step();
    step();
    reset    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    din      = 4'b0000;
    ev_ready = 1'b0;
    #2;

    // Reset state
    do_reset(4'b0000);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_id",    32'(ev_id),    32'd0);
    check("rst_pend",  32'(pend_any), 32'd0);
    check("rst_ovf",   32'(ovf),      32'd0);

    // 1: single edge on ch2
    ev_ready = 1'b1;
    din = 4'b0100;
    step();
    check("t1_valid_k",   32'(ev_valid), 32'd0);
    check("t1_pend_k",    32'(pend_any), 32'd1);
    step();
    check("t1_valid_k1",  32'(ev_valid), 32'd1);
    check("t1_id_k1",     32'(ev_id),    32'd2);
    check("t1_pend_k1",   32'(pend_any), 32'd0);
    step();
    check("t1_valid_k2",  32'(ev_valid), 32'd0);

    // 2: all four channels rise together -> ids 0,1,2,3
    do_reset(4'b0000);
    ev_ready = 1'b1;
    din = 4'b1111;
    step();
    check("t2_valid0", 32'(ev_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_valid", 32'(ev_valid), 32'd1);
      check("t2_id",    32'(ev_id),    32'(i));
    end
    step();
    check("t2_idle", 32'(ev_valid), 32'd0);

    // 3: three pulses on ch1 under backpressure, then drain
    do_reset(4'b0000);
    for (int i = 0; i < 3; i++) begin
      din = 4'b0010;
      step();
      din = 4'b0000;
      step();
    end
    check("t3_hold_valid", 32'(ev_valid), 32'd1);
    check("t3_hold_id",    32'(ev_id),    32'd1);
    check("t3_hold_pend",  32'(pend_any), 32'd1);
    ev_ready = 1'b1;
    step();
    check("t3_e2_valid", 32'(ev_valid), 32'd1);
    check("t3_e2_id",    32'(ev_id),    32'd1);
    check("t3_e2_pend",  32'(pend_any), 32'd1);
    step();
    check("t3_e3_valid", 32'(ev_valid), 32'd1);
    check("t3_e3_id",    32'(ev_id),    32'd1);
    check("t3_e3_pend",  32'(pend_any), 32'd0);
    step();
    check("t3_done",     32'(ev_valid), 32'd0);
    check("t3_ovf",      32'(ovf),      32'd0);

    // 4: nine edges on ch0 with ready low -> 7 pending + 1 held, overflow set
    do_reset(4'b0000);
    for (int i = 0; i < 9; i++) begin
      din = 4'b0001;
      step();
      din = 4'b0000;
      step();
    end
    check("t4_valid", 32'(ev_valid), 32'd1);
    check("t4_id",    32'(ev_id),    32'd0);
    check("t4_pend",  32'(pend_any), 32'd1);
    check("t4_ovf",   32'(ovf),      32'h1);
    ev_ready = 1'b1;
    ev_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (ev_valid) begin
        ev_cnt++;
      end
      step();
    end
    check("t4_events",     32'(ev_cnt),   32'd8);
    check("t4_ovf_sticky", 32'(ovf),      32'h1);
    check("t4_drained",    32'(pend_any), 32'd0);

    // 5: ch0 and ch3 re-pend every other cycle -> strict alternation
    do_reset(4'b0000);
    ev_ready = 1'b1;
    din = 4'b1001;
    step();
    for (int i = 0; i < 6; i++) begin
      din = (i % 2 == 0) ? 4'b0000 : 4'b1001;
      step();
      check("t5_valid", 32'(ev_valid), 32'd1);
      check("t5_id",    32'(ev_id),    (i % 2 == 0) ? 32'd0 : 32'd3);
    end

    // 6a: din[0] held high through reset counts as one rise after reset
    do_reset(4'b0001);
    ev_ready = 1'b1;
    step();
    check("t6_pend",   32'(pend_any), 32'd1);
    check("t6_valid0", 32'(ev_valid), 32'd0);
    step();
    check("t6_valid1", 32'(ev_valid), 32'd1);
    check("t6_id",     32'(ev_id),    32'd0);
    step();
    check("t6_once",   32'(ev_valid), 32'd0);

    // 6b: reset during a stall drops the held event and pending counts
    ev_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din = 4'b0010;
      step();
      din = 4'b0000;
      step();
    end
    check("t6_stall_valid", 32'(ev_valid), 32'd1);
    check("t6_stall_pend",  32'(pend_any), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_valid", 32'(ev_valid), 32'd0);
    check("t6_rst_pend",  32'(pend_any), 32'd0);
    check("t6_rst_ovf",   32'(ovf),      32'd0);
    ev_ready = 1'b1;
    step();
    check("t6_after", 32'(ev_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
